// File: rtl/ddr2_pipe_sequencer.sv
// Moves FrontPanel pipe data to and from MIG port 0 of the DDR2 controller.
// Write bursts drain the pipe-in FIFO and read bursts refill the pipe-out FIFO, both over a wrapping window.
module ddr2_pipe_sequencer #(
    parameter int          BURST_LEN = 32,
    parameter logic [29:0] ADDR_MIN  = 30'h0000_0000,
    parameter logic [29:0] ADDR_MAX  = 30'h0000_03FF,
    parameter int          OB_DEPTH  = 512
) (
    input  logic        c3_clk0,
    input  logic        c3_rst0,
    input  logic        calib_done,
    input  logic        write_mode,
    input  logic        read_mode,
    input  logic        fifo_reset,
    input  logic [9:0]  ib_count,
    input  logic [31:0] ib_data,
    output logic        ib_re,
    input  logic [9:0]  ob_count,
    output logic        ob_we,
    output logic [31:0] ob_data,
    output logic        p0_cmd_en,
    output logic [2:0]  p0_cmd_instr,
    output logic [5:0]  p0_cmd_bl,
    output logic [29:0] p0_cmd_byte_addr,
    input  logic        p0_cmd_full,
    output logic        p0_wr_en,
    output logic [31:0] p0_wr_data,
    input  logic        p0_wr_full,
    output logic        p0_rd_en,
    input  logic [31:0] p0_rd_data,
    input  logic        p0_rd_empty
);

    localparam logic [30:0] BURST_BYTES = 31'(BURST_LEN * 4);
    localparam logic [6:0]  LAST_WORD   = 7'(BURST_LEN - 1);
    localparam logic [9:0]  IB_NEEDED   = 10'(BURST_LEN);
    localparam logic [9:0]  OB_LIMIT    = 10'(OB_DEPTH - BURST_LEN);
    localparam logic [2:0]  INSTR_WR    = 3'b000;
    localparam logic [2:0]  INSTR_RD    = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        WR_FILL,
        WR_CMD,
        RD_CMD,
        RD_DRAIN
    } state_t;

    state_t      state;
    logic [29:0] wr_addr;
    logic [29:0] rd_addr;
    logic [6:0]  word_cnt;
    logic        start_wr;
    logic        start_rd;

    // Advance one burst and wrap back to the window base once past the top.
    function automatic logic [29:0] next_addr(input logic [29:0] addr);
        logic [30:0] sum;
        sum = {1'b0, addr} + BURST_BYTES;
        return (sum > {1'b0, ADDR_MAX}) ? ADDR_MIN : sum[29:0];
    endfunction

    assign start_wr = calib_done && write_mode && (ib_count >= IB_NEEDED);
    assign start_rd = calib_done && read_mode && (ob_count <= OB_LIMIT);

    // Both FIFO heads are first-word-fall-through, so the pops are qualified
    // by this cycle's full/empty flags and only ever asserted inside a burst.
    assign ib_re    = (state == WR_FILL) && !p0_wr_full;
    assign p0_rd_en = (state == RD_DRAIN) && !p0_rd_empty;

    // NOTE: every register below uses <= so all of them sample the same pre-edge values.
    always_ff @(posedge c3_clk0 or posedge c3_rst0) begin
        if (c3_rst0) begin
            state            <= IDLE;
            wr_addr          <= ADDR_MIN;
            rd_addr          <= ADDR_MIN;
            word_cnt         <= '0;
            p0_wr_en         <= 1'b0;
            p0_wr_data       <= '0;
            ob_we            <= 1'b0;
            ob_data          <= '0;
            p0_cmd_en        <= 1'b0;
            p0_cmd_instr     <= '0;
            p0_cmd_bl        <= '0;
            p0_cmd_byte_addr <= '0;
        end else begin
            p0_wr_en  <= ib_re;
            ob_we     <= p0_rd_en;
            p0_cmd_en <= 1'b0;
            if (ib_re)
                p0_wr_data <= ib_data;
            if (p0_rd_en)
                ob_data <= p0_rd_data;

            case (state)
                IDLE: begin
                    word_cnt <= '0;
                    if (fifo_reset) begin
                        wr_addr <= ADDR_MIN;
                        rd_addr <= ADDR_MIN;
                    end else if (start_wr) begin
                        state <= WR_FILL;
                    end else if (start_rd) begin
                        state <= RD_CMD;
                    end
                end

                WR_FILL: begin
                    if (ib_re) begin
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            state    <= WR_CMD;
                        end else begin
                            word_cnt <= word_cnt + 7'd1;
                        end
                    end
                end

                // The last data word is pushed in the first WR_CMD cycle, so the
                // registered strobe always trails it by at least one cycle.
                WR_CMD: begin
                    if (!p0_cmd_full) begin
                        p0_cmd_en        <= 1'b1;
                        p0_cmd_instr     <= INSTR_WR;
                        p0_cmd_bl        <= 6'(BURST_LEN - 1);
                        p0_cmd_byte_addr <= wr_addr;
                        wr_addr          <= next_addr(wr_addr);
                        state            <= IDLE;
                    end
                end

                RD_CMD: begin
                    if (!p0_cmd_full) begin
                        p0_cmd_en        <= 1'b1;
                        p0_cmd_instr     <= INSTR_RD;
                        p0_cmd_bl        <= 6'(BURST_LEN - 1);
                        p0_cmd_byte_addr <= rd_addr;
                        rd_addr          <= next_addr(rd_addr);
                        word_cnt         <= '0;
                        state            <= RD_DRAIN;
                    end
                end

                RD_DRAIN: begin
                    if (p0_rd_en) begin
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            word_cnt <= word_cnt + 7'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr2_pipe_sequencer.sv
// Randomized bench for ddr2_pipe_sequencer: queue models of the pipe FIFOs and MIG port
// predict the written stream, read stream and burst addresses.
module tb_ddr2_pipe_sequencer;

    localparam int          BURST_LEN = 32;
    localparam logic [29:0] ADDR_MIN  = 30'h0000_0000;
    localparam logic [29:0] ADDR_MAX  = 30'h0000_03FF;
    localparam int          OB_DEPTH  = 512;
    localparam int          WIN_BYTES = 1024;

    logic        c3_clk0;
    logic        c3_rst0;
    logic        calib_done;
    logic        write_mode;
    logic        read_mode;
    logic        fifo_reset;
    logic [9:0]  ib_count;
    logic [31:0] ib_data;
    logic        ib_re;
    logic [9:0]  ob_count;
    logic        ob_we;
    logic [31:0] ob_data;
    logic        p0_cmd_en;
    logic [2:0]  p0_cmd_instr;
    logic [5:0]  p0_cmd_bl;
    logic [29:0] p0_cmd_byte_addr;
    logic        p0_cmd_full;
    logic        p0_wr_en;
    logic [31:0] p0_wr_data;
    logic        p0_wr_full;
    logic        p0_rd_en;
    logic [31:0] p0_rd_data;
    logic        p0_rd_empty;

    ddr2_pipe_sequencer #(
        .BURST_LEN(BURST_LEN),
        .ADDR_MIN (ADDR_MIN),
        .ADDR_MAX (ADDR_MAX),
        .OB_DEPTH (OB_DEPTH)
    ) dut (
        .c3_clk0         (c3_clk0),
        .c3_rst0         (c3_rst0),
        .calib_done      (calib_done),
        .write_mode      (write_mode),
        .read_mode       (read_mode),
        .fifo_reset      (fifo_reset),
        .ib_count        (ib_count),
        .ib_data         (ib_data),
        .ib_re           (ib_re),
        .ob_count        (ob_count),
        .ob_we           (ob_we),
        .ob_data         (ob_data),
        .p0_cmd_en       (p0_cmd_en),
        .p0_cmd_instr    (p0_cmd_instr),
        .p0_cmd_bl       (p0_cmd_bl),
        .p0_cmd_byte_addr(p0_cmd_byte_addr),
        .p0_cmd_full     (p0_cmd_full),
        .p0_wr_en        (p0_wr_en),
        .p0_wr_data      (p0_wr_data),
        .p0_wr_full      (p0_wr_full),
        .p0_rd_en        (p0_rd_en),
        .p0_rd_data      (p0_rd_data),
        .p0_rd_empty     (p0_rd_empty)
    );

    initial c3_clk0 = 1'b0;
    always #5 c3_clk0 = ~c3_clk0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Environment and reference model state.
    logic [31:0] ib_q[$];
    logic [31:0] wr_exp_q[$];
    logic [31:0] rd_mig_q[$];
    logic [31:0] rd_exp_q[$];
    int wr_idx = 0, rd_idx = 0;
    int wr_bursts = 0, rd_bursts = 0;
    int wr_words = 0, ob_words = 0;
    int rd_seq = 0;
    bit feed = 0, full_rand = 0, full_toggle = 0, cmd_full_rand = 0, empty_rand = 0, quiet_chk = 0;

    // The n-th burst since the window was rewound lands at base + n bursts, modulo the window.
    function automatic logic [31:0] exp_addr(input int n);
        return 32'(ADDR_MIN) + 32'((n * BURST_LEN * 4) % WIN_BYTES);
    endfunction

    task automatic drive_inputs();
        logic [31:0] w;
        if (feed) begin
            while (ib_q.size() < 48) begin
                w = $urandom;
                ib_q.push_back(w);
                wr_exp_q.push_back(w);
            end
        end
        ib_count    = 10'(ib_q.size());
        ib_data     = (ib_q.size() > 0) ? ib_q[0] : 32'h0;
        p0_wr_full  = full_toggle ? ~p0_wr_full : (full_rand ? ($urandom_range(0, 1) == 1) : 1'b0);
        p0_cmd_full = cmd_full_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
        p0_rd_empty = (rd_mig_q.size() == 0) || (empty_rand && ($urandom_range(0, 2) == 0));
        p0_rd_data  = (rd_mig_q.size() > 0) ? rd_mig_q[0] : 32'h0;
    endtask

    // One clock: observe at the falling edge, then update the environment just after the rising edge.
    task automatic step();
        bit pop_ib, pop_rd;
        @(negedge c3_clk0);
        if (p0_wr_en) begin
            if (wr_exp_q.size() == 0) check("wr_extra_word", 32'(wr_exp_q.size()), 1);
            else check("wr_data", p0_wr_data, wr_exp_q.pop_front());
            wr_words++;
        end
        if (ob_we) begin
            if (rd_exp_q.size() == 0) check("ob_extra_word", 32'(rd_exp_q.size()), 1);
            else check("ob_data", ob_data, rd_exp_q.pop_front());
            ob_words++;
        end
        if (p0_cmd_en) begin
            check("cmd_bl", 32'(p0_cmd_bl), BURST_LEN - 1);
            if (p0_cmd_instr == 3'b000) begin
                check("wr_cmd_addr", 32'(p0_cmd_byte_addr), exp_addr(wr_idx));
                check("wr_burst_words", wr_words, BURST_LEN);
                check("wr_cmd_after_data", 32'(p0_wr_en), 0);
                wr_idx++;
                wr_bursts++;
                wr_words = 0;
            end else begin
                check("rd_cmd_instr", 32'(p0_cmd_instr), 3'b001);
                check("rd_cmd_addr", 32'(p0_cmd_byte_addr), exp_addr(rd_idx));
                rd_idx++;
                rd_bursts++;
                repeat (BURST_LEN) begin
                    rd_mig_q.push_back(32'hA500_0000 + 32'(rd_seq));
                    rd_exp_q.push_back(32'hA500_0000 + 32'(rd_seq));
                    rd_seq++;
                end
            end
        end
        if (ib_re) check("ib_re_while_full", 32'(p0_wr_full), 0);
        if (p0_rd_en) check("rd_en_while_empty", 32'(p0_rd_empty), 0);
        if (quiet_chk) check("calib_quiet", 32'({p0_cmd_en, ib_re, p0_rd_en, ob_we}), 0);
        pop_ib = ib_re;
        pop_rd = p0_rd_en;
        @(posedge c3_clk0);
        #1;
        if (pop_ib && ib_q.size() > 0) ib_q.delete(0);
        if (pop_rd && rd_mig_q.size() > 0) rd_mig_q.delete(0);
        drive_inputs();
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic wait_bursts(input bit is_rd, input int target, input int budget);
        int n = 0;
        while (((is_rd ? rd_bursts : wr_bursts) < target) && n < budget) begin
            step();
            n++;
        end
        if ((is_rd ? rd_bursts : wr_bursts) < target)
            check(is_rd ? "rd_burst_timeout" : "wr_burst_timeout", is_rd ? rd_bursts : wr_bursts, target);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cmd_en"}, 32'(p0_cmd_en), 0);
        check({tag, "_cmd_instr"}, 32'(p0_cmd_instr), 0);
        check({tag, "_cmd_bl"}, 32'(p0_cmd_bl), 0);
        check({tag, "_cmd_addr"}, 32'(p0_cmd_byte_addr), 0);
        check({tag, "_wr_en"}, 32'(p0_wr_en), 0);
        check({tag, "_wr_data"}, p0_wr_data, 0);
        check({tag, "_ib_re"}, 32'(ib_re), 0);
        check({tag, "_rd_en"}, 32'(p0_rd_en), 0);
        check({tag, "_ob_we"}, 32'(ob_we), 0);
        check({tag, "_ob_data"}, ob_data, 0);
    endtask

    task automatic check_stream_idle(input string tag);
        check({tag, "_wr_partial"}, wr_words, 0);
        check({tag, "_ob_total"}, ob_words, rd_bursts * BURST_LEN);
        check({tag, "_mig_rd_left"}, 32'(rd_mig_q.size()), 0);
    endtask

    initial begin
        int base_w, base_r, base_ob;
        c3_rst0 = 1'b1;
        calib_done = 1'b0;
        write_mode = 1'b0;
        read_mode = 1'b0;
        fifo_reset = 1'b0;
        ob_count = '0;
        p0_wr_full = 1'b0;
        drive_inputs();
        #12;
        check_outputs_zero("reset");
        @(posedge c3_clk0);
        #1;
        c3_rst0 = 1'b0;
        calib_done = 1'b1;

        // Directed write burst: data 0..31 to address 0.
        for (int i = 0; i < BURST_LEN; i++) begin
            ib_q.push_back(32'(i));
            wr_exp_q.push_back(32'(i));
        end
        drive_inputs();
        write_mode = 1'b1;
        wait_bursts(0, 1, 300);
        write_mode = 1'b0;
        drain(100);
        check_stream_idle("dir_wr");

        // Random write bursts with back-pressure, running past the window wrap.
        feed = 1; full_rand = 1; cmd_full_rand = 1;
        write_mode = 1'b1;
        wait_bursts(0, 11, 4000);
        write_mode = 1'b0;
        drain(250);
        check_stream_idle("rnd_wr");
        full_rand = 0; cmd_full_rand = 0; feed = 0;

        // Directed read burst with a steady read-data FIFO.
        read_mode = 1'b1;
        wait_bursts(1, rd_bursts + 1, 300);
        read_mode = 1'b0;
        drain(100);
        check_stream_idle("dir_rd");

        // Random read bursts with empty and command-full stalls.
        empty_rand = 1; cmd_full_rand = 1;
        read_mode = 1'b1;
        wait_bursts(1, rd_bursts + 3, 2000);
        read_mode = 1'b0;
        drain(250);
        check_stream_idle("rnd_rd");
        empty_rand = 0; cmd_full_rand = 0;

        // Soft clear rewinds both windows.
        fifo_reset = 1'b1;
        drain(3);
        fifo_reset = 1'b0;
        wr_idx = 0;
        rd_idx = 0;

        // Write data FIFO full on alternate cycles.
        feed = 1; full_toggle = 1;
        write_mode = 1'b1;
        wait_bursts(0, wr_bursts + 1, 400);
        write_mode = 1'b0;
        drain(200);
        check_stream_idle("toggle_wr");
        full_toggle = 0;

        // Pipe-out occupancy threshold.
        ob_count = 10'd481;
        read_mode = 1'b1;
        base_r = rd_bursts;
        drain(20);
        check("no_rd_at_481", rd_bursts, base_r);
        ob_count = 10'd480;
        drain(3);
        check("rd_at_480", rd_bursts, base_r + 1);
        read_mode = 1'b0;
        ob_count = '0;
        drain(100);
        check_stream_idle("thresh");

        // No activity at all until calibration completes.
        calib_done = 1'b0;
        base_w = wr_bursts;
        base_r = rd_bursts;
        write_mode = 1'b1;
        read_mode = 1'b1;
        quiet_chk = 1;
        drain(30);
        quiet_chk = 0;
        check("calib_no_wr", wr_bursts, base_w);
        check("calib_no_rd", rd_bursts, base_r);
        write_mode = 1'b0;
        read_mode = 1'b0;
        drain(1);
        calib_done = 1'b1;
        feed = 0;

        // Hard reset in the middle of a read drain.
        empty_rand = 1;
        read_mode = 1'b1;
        base_ob = ob_words + 8;
        begin
            int n = 0;
            while ((ob_words < base_ob || rd_mig_q.size() == 0) && n < 500) begin
                step();
                n++;
            end
            if (ob_words < base_ob) check("drain_timeout", ob_words, base_ob);
        end
        p0_rd_empty = (rd_mig_q.size() == 0);
        #3;
        c3_rst0 = 1'b1;
        #1;
        check_outputs_zero("mid_rst");
        rd_mig_q.delete();
        rd_exp_q.delete();
        wr_exp_q = ib_q;
        wr_idx = 0; rd_idx = 0;
        wr_words = 0; ob_words = 0;
        rd_bursts = 0;
        empty_rand = 0;
        @(posedge c3_clk0);
        #1;
        drive_inputs();
        c3_rst0 = 1'b0;
        wait_bursts(1, 1, 300);
        read_mode = 1'b0;
        drain(100);
        check_stream_idle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr2_pipe_sequencer.md
Name: ddr2_pipe_sequencer

Overview:
- User-side responder between the FrontPanel pipe FIFOs (PipeIn 0x80, PipeOut 0xA0) and MIG port 0 of the C3 DDR2 controller in the RAM tester.
- Write mode: drains host data from the pipe-in FIFO into DDR2 bursts. Read mode: issues DDR2 read bursts and refills the pipe-out FIFO. Both use a wrapping address window.

Parameters:
- BURST_LEN, 32: words per MIG burst (1..64). p0_cmd_bl = BURST_LEN-1.
- ADDR_MIN, 30'h0000_0000: first byte address of the window; BURST_LEN*4 aligned.
- ADDR_MAX, 30'h0000_03FF: last byte address of the window; window size is a multiple of BURST_LEN*4.
- OB_DEPTH, 512: pipe-out FIFO depth in 32-bit words.

Ports:
c3_clk0  input  1  user clock (MIG user clock domain)
c3_rst0  input  1  asynchronous active-high reset
calib_done  input  1  DDR2 calibration complete; no commands are issued while low
write_mode  input  1  wire-in 0x00 bit1
read_mode  input  1  wire-in 0x00 bit0
fifo_reset  input  1  wire-in 0x00 bit2; level, synchronous soft clear
ib_count  input  10  words available in pipe-in FIFO
ib_data  input  32  pipe-in FIFO head word (first-word-fall-through)
ib_re  output  1  pipe-in FIFO pop
ob_count  input  10  words stored in pipe-out FIFO
ob_we  output  1  pipe-out FIFO push
ob_data  output  32  pipe-out FIFO write data
p0_cmd_en  output  1  MIG command strobe
p0_cmd_instr  output  3  3'b000 write, 3'b001 read
p0_cmd_bl  output  6  burst length minus one
p0_cmd_byte_addr  output  30  burst byte address
p0_cmd_full  input  1  MIG command FIFO full
p0_wr_en  output  1  MIG write-data push
p0_wr_data  output  32  MIG write data
p0_wr_full  input  1  MIG write-data FIFO full
p0_rd_en  output  1  MIG read-data pop
p0_rd_data  input  32  MIG read data
p0_rd_empty  input  1  MIG read-data FIFO empty

Behaviour:
- Reset: all outputs are 0. State is IDLE. wr_addr = rd_addr = ADDR_MIN. Word counter is 0.
- States: IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DRAIN.
- IDLE:
  - If fifo_reset=1: wr_addr and rd_addr are set to ADDR_MIN; stay in IDLE.
  - Else if calib_done=1 and write_mode=1 and ib_count>=BURST_LEN: go to WR_FILL.
  - Else if calib_done=1 and read_mode=1 and ob_count<=OB_DEPTH-BURST_LEN: go to RD_CMD.
  - Write has priority when both modes are set.
- WR_FILL:
  - ib_re = !p0_wr_full. Each pop registers p0_wr_en=1 and p0_wr_data=ib_data one cycle later.
  - Exactly BURST_LEN pops, then go to WR_CMD.
  - p0_wr_full stalls the fill with no word lost or duplicated.
- WR_CMD:
  - Wait for p0_cmd_full=0, then pulse p0_cmd_en for one cycle with instr 000, bl BURST_LEN-1, addr wr_addr.
  - The command is issued no earlier than the cycle after the last p0_wr_en.
  - Then wr_addr += BURST_LEN*4; if the result exceeds ADDR_MAX it becomes ADDR_MIN. Return to IDLE.
- RD_CMD:
  - Wait for p0_cmd_full=0, pulse p0_cmd_en with instr 001 and addr rd_addr.
  - rd_addr advances and wraps identically to wr_addr. Go to RD_DRAIN.
- RD_DRAIN:
  - p0_rd_en = !p0_rd_empty. Each pop registers ob_we=1 and ob_data=p0_rd_data one cycle later.
  - Return to IDLE after BURST_LEN pops.
- Mode deassertion or fifo_reset mid-burst: the current burst always completes. fifo_reset is honoured on return to IDLE.
- p0_cmd_en, ib_re, p0_rd_en and ob_we are never asserted while calib_done=0 in IDLE.
- c3_rst0 mid-burst forces everything to reset values immediately. The partial MIG burst is discarded by the top-level MIG reset.

Test Plan:
- write_mode=1, ib_count=32, ib_data=0..31 -> 32 p0_wr_en pulses with data 0..31, then one p0_cmd_en with instr 000, bl 31, addr 0x000. The next burst uses addr 0x080.
- 8 consecutive write bursts -> addresses 0x000, 0x080, …, 0x380; the 9th burst wraps to 0x000.
- read_mode=1, ob_count=0, p0_rd_data=0xA5000000+n -> cmd instr 001 addr 0x000, then 32 ob_we pulses with matching data, in order.
- ob_count=481 -> no read command; drop ob_count to 480 -> command issued within 2 cycles. Repeat with calib_done=0 -> nothing issued.
- p0_wr_full toggled every other cycle during WR_FILL -> exactly 32 words written, no duplicates.
- c3_rst0 pulsed mid RD_DRAIN -> all outputs 0 in the same cycle; after release the next read uses addr 0x000.
